axi_stream_input: RTL and testbench

- Upstream counterpart of the output streamer. Accepts an AXI4-Stream slave feed from the DMA/host side.
- Packs PACK consecutive beats of DATA_WIDTH bits into one SRAM word and writes it to the input SRAM that the NPU compute core reads.
- Reports received length, first-beat tuser (channel count) and a done pulse to the top-level controller.

---
 rtl/axi_stream_input.sv | 203 ++++++++++++++++++++
 tb/tb_axi_stream_input.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_input.sv
// AXI4-Stream slave that packs PACK beats per word into the NPU input SRAM.
// Optional AXIS_IN_LEN_CHECK_EN adds a len_err output flagging length mismatches.
module axi_stream_input #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned PACK               = 4,
  parameter int unsigned SRAM_WIDTH_I       = DATA_WIDTH * PACK,
  parameter int unsigned MAX_ADDR_WIDTH     = 13,
  parameter int unsigned SIZE_WIDTH         = 16,
  parameter int unsigned NUM_CHANNELS_WIDTH = $clog2(64 + 1)
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
  output logic                          sram_in_en,
  output logic [MAX_ADDR_WIDTH-1:0]     sram_in_addr,
  output logic [SRAM_WIDTH_I-1:0]       sram_in_data,
  input  logic                          start_input,
  input  logic [SIZE_WIDTH-1:0]         in_size,
  output logic [SIZE_WIDTH-1:0]         in_count,
  output logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
  output logic                          in_done,
  output logic                          in_busy
`ifdef AXIS_IN_LEN_CHECK_EN
  ,
  output logic                          len_err
`endif
);

  localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic                          tready_q, tready_d;
  logic                          en_q, en_d;
  logic [MAX_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [SRAM_WIDTH_I-1:0]       data_q, data_d;
  logic [SIZE_WIDTH-1:0]         count_q, count_d;
  logic [NUM_CHANNELS_WIDTH-1:0] nch_q, nch_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;
  logic [SIZE_WIDTH-1:0]         size_q, size_d;
  logic [LANE_W-1:0]             lane_q, lane_d;
  logic [MAX_ADDR_WIDTH-1:0]     waddr_q, waddr_d;
  logic [SRAM_WIDTH_I-1:0]       pack_q, pack_d;
`ifdef AXIS_IN_LEN_CHECK_EN
  logic                          err_pend_q, err_pend_d;
  logic                          len_err_q, len_err_d;
`endif

  logic                          accept_c;
  logic                          end_c;
  logic [SIZE_WIDTH-1:0]         cnt_inc_c;
  logic [SRAM_WIDTH_I-1:0]       word_c;

  // Next-state, packing and output decode
  always_comb begin
    state_d  = state_q;
    en_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q;
    nch_d    = nch_q;
    size_d   = size_q;
    lane_d   = lane_q;
    waddr_d  = waddr_q;
    pack_d   = pack_q;
`ifdef AXIS_IN_LEN_CHECK_EN
    err_pend_d = err_pend_q;
    len_err_d  = len_err_q;
`endif
    accept_c  = s_axis_tvalid && tready_q;
    cnt_inc_c = count_q + SIZE_WIDTH'(1);
    end_c     = s_axis_tlast || ((size_q != '0) && (cnt_inc_c == size_q));
    word_c    = pack_q;
    word_c[lane_q*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;

    case (state_q)
      ST_IDLE: begin
        if (start_input) begin
          state_d = ST_RECV;
          size_d  = in_size;
          count_d = '0;
          nch_d   = '0;
          lane_d  = '0;
          waddr_d = '0;
          pack_d  = '0;
`ifdef AXIS_IN_LEN_CHECK_EN
          err_pend_d = 1'b0;
          len_err_d  = 1'b0;
`endif
        end
      end
      ST_RECV: begin
        if (accept_c) begin
          count_d = cnt_inc_c;
          if (count_q == '0) nch_d = s_axis_tuser;
          // Lanes are cleared after each full word so a later partial word is zero padded
          if (lane_q == LAST_LANE) begin
            lane_d  = '0;
            pack_d  = '0;
            en_d    = 1'b1;
            data_d  = word_c;
            addr_d  = waddr_q;
            waddr_d = waddr_q + MAX_ADDR_WIDTH'(1);
          end else begin
            lane_d = lane_q + LANE_W'(1);
            pack_d = word_c;
          end
          if (end_c) begin
            state_d = ST_FLUSH;
`ifdef AXIS_IN_LEN_CHECK_EN
            err_pend_d = (size_q != '0) && (!s_axis_tlast || (cnt_inc_c < size_q));
`endif
          end
        end
      end
      ST_FLUSH: begin
        if (lane_q != '0) begin
          en_d    = 1'b1;
          data_d  = pack_q;
          addr_d  = waddr_q;
          waddr_d = waddr_q + MAX_ADDR_WIDTH'(1);
          lane_d  = '0;
          pack_d  = '0;
        end
        state_d = ST_DONE;
`ifdef AXIS_IN_LEN_CHECK_EN
        len_err_d = err_pend_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tready_d = (state_d == ST_RECV);
    busy_d   = (state_d == ST_RECV) || (state_d == ST_FLUSH);
    done_d   = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q  <= ST_IDLE;
      tready_q <= 1'b0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      count_q  <= '0;
      nch_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      size_q   <= '0;
      lane_q   <= '0;
      waddr_q  <= '0;
      pack_q   <= '0;
`ifdef AXIS_IN_LEN_CHECK_EN
      err_pend_q <= 1'b0;
      len_err_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      count_q  <= count_d;
      nch_q    <= nch_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      waddr_q  <= waddr_d;
      pack_q   <= pack_d;
`ifdef AXIS_IN_LEN_CHECK_EN
      err_pend_q <= err_pend_d;
      len_err_q  <= len_err_d;
`endif
    end
  end

  assign s_axis_tready = tready_q;
  assign sram_in_en    = en_q;
  assign sram_in_addr  = addr_q;
  assign sram_in_data  = data_q;
  assign in_count      = count_q;
  assign num_channels  = nch_q;
  assign in_done       = done_q;
  assign in_busy       = busy_q;
`ifdef AXIS_IN_LEN_CHECK_EN
  assign len_err       = len_err_q;
`endif

endmodule

// File: tb/tb_axi_stream_input.sv
// Self-checking bench for axi_stream_input: directed packets plus random
// packets against a queue-based model of the packing/termination rules.
module tb_axi_stream_input;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int SW = DW * PK;
  localparam int AW = 13;
  localparam int ZW = 16;
  localparam int NW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [NW-1:0] s_axis_tuser = '0;
  logic          sram_in_en;
  logic [AW-1:0] sram_in_addr;
  logic [SW-1:0] sram_in_data;
  logic          start_input = 1'b0;
  logic [ZW-1:0] in_size = '0;
  logic [ZW-1:0] in_count;
  logic [NW-1:0] num_channels;
  logic          in_done;
  logic          in_busy;
`ifdef AXIS_IN_LEN_CHECK_EN
  logic          len_err;
`endif

  axi_stream_input dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .sram_in_en     (sram_in_en),
    .sram_in_addr   (sram_in_addr),
    .sram_in_data   (sram_in_data),
    .start_input    (start_input),
    .in_size        (in_size),
    .in_count       (in_count),
    .num_channels   (num_channels),
    .in_done        (in_done),
    .in_busy        (in_busy)
`ifdef AXIS_IN_LEN_CHECK_EN
    ,
    .len_err        (len_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic prev_busy = 1'b0;

  logic [AW-1:0] exp_addr_q[$];
  logic [SW-1:0] exp_data_q[$];
  logic [AW-1:0] cap_addr[$];
  logic [SW-1:0] cap_data[$];

  logic [DW-1:0] pk_data[64];
  logic [NW-1:0] pk_user[64];
  bit            pk_last[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, 64'(s_axis_tready), 64'(0));
    check({tag, "_en"},     64'(sram_in_en),    64'(0));
    check({tag, "_addr"},   64'(sram_in_addr),  64'(0));
    check({tag, "_data"},   64'(sram_in_data),  64'(0));
    check({tag, "_count"},  64'(in_count),      64'(0));
    check({tag, "_nch"},    64'(num_channels),  64'(0));
    check({tag, "_done"},   64'(in_done),       64'(0));
    check({tag, "_busy"},   64'(in_busy),       64'(0));
`ifdef AXIS_IN_LEN_CHECK_EN
    check({tag, "_lenerr"}, 64'(len_err),       64'(0));
`endif
  endtask

  // Per-cycle compare of SRAM writes and handshake/status relations
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_in_en) begin
        cap_addr.push_back(sram_in_addr);
        cap_data.push_back(sram_in_data);
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 64'(sram_in_addr), 64'hFFFF_FFFF);
        end else begin
          check("wr_addr", 64'(sram_in_addr), 64'(exp_addr_q.pop_front()));
          check("wr_data", 64'(sram_in_data), 64'(exp_data_q.pop_front()));
        end
      end
      if (in_done) begin
        done_cnt++;
        check("done_after_busy", 64'({prev_busy, in_busy}), 64'(2'b10));
      end
      if (!in_busy && s_axis_tready) check("tready_idle", 64'(s_axis_tready), 64'(0));
    end
    prev_busy = in_busy;
  end

  task automatic clear_pkt();
    for (int i = 0; i < 64; i++) begin
      pk_data[i] = '0;
      pk_user[i] = '0;
      pk_last[i] = 1'b0;
    end
  endtask

  // Model: packet ends at first tlast or at beat number == size; words are
  // little-endian lane packs, zero padded, addressed from 0.
  task automatic run_packet(input logic [ZW-1:0] size, input bit alt, input int gap_pct,
                            input bit start_mid, input int abort_at);
    int term, n, nwords, d0, waits, idx;
    logic [SW-1:0] w;
    bit ok, exp_err;
    term = 63;
    for (int i = 0; i < 64; i++) begin
      if (pk_last[i] || (size != '0 && i + 1 == int'(size))) begin
        term = i;
        break;
      end
    end
    n = (abort_at >= 0) ? abort_at : term + 1;
    nwords = (abort_at >= 0) ? n / PK : (n + PK - 1) / PK;
    exp_err = (size != '0) && (!pk_last[term] || (term + 1) < int'(size));
    for (int wi = 0; wi < nwords; wi++) begin
      w = '0;
      for (int l = 0; l < PK; l++) begin
        idx = wi * PK + l;
        if (idx < n) w = w | (SW'(pk_data[idx]) << (DW * l));
      end
      exp_addr_q.push_back(AW'(wi));
      exp_data_q.push_back(w);
    end
    cap_addr.delete();
    cap_data.delete();
    d0 = done_cnt;

    @(negedge clk);
    in_size = size;
    start_input = 1'b1;
    @(negedge clk);
    start_input = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      if (alt && i > 0) begin
        s_axis_tvalid = 1'b0;
        check("tready_hold", 64'(s_axis_tready), 64'(1));
        @(negedge clk);
      end else begin
        while ($urandom_range(0, 99) < gap_pct) begin
          s_axis_tvalid = 1'b0;
          s_axis_tdata = DW'($urandom);
          s_axis_tlast = 1'b1;
          check("tready_hold", 64'(s_axis_tready), 64'(1));
          @(negedge clk);
        end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata = pk_data[i];
      s_axis_tuser = pk_user[i];
      s_axis_tlast = pk_last[i];
      if (start_mid && i == 1) start_input = 1'b1;
      waits = 0;
      while (!s_axis_tready && waits < 20) begin
        @(negedge clk);
        start_input = 1'b0;
        waits++;
      end
      if (!s_axis_tready) begin
        check("tready_timeout", 64'(0), 64'(1));
        ok = 1'b0;
      end else begin
        @(negedge clk);
        start_input = 1'b0;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;

    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      check("rst_mid_words_done", 64'(exp_addr_q.size()), 64'(0));
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    waits = 0;
    while (done_cnt == d0 && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'(1));
    check("in_count", 64'(in_count), 64'(n));
    check("num_channels", 64'(num_channels), 64'(pk_user[0]));
    check("words_left", 64'(exp_addr_q.size()), 64'(0));
`ifdef AXIS_IN_LEN_CHECK_EN
    check("len_err", 64'(len_err), 64'(exp_err));
`else
    if (exp_err) w = '0;
`endif
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check("done_single", 64'(done_cnt - d0), 64'(1));
    check("idle_busy", 64'(in_busy), 64'(0));
    check("hold_count", 64'(in_count), 64'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 8 beats, size 8, tlast on beat 8
    clear_pkt();
    for (int i = 0; i < 8; i++) begin
      pk_data[i] = DW'(i + 1);
      pk_user[i] = NW'(5);
    end
    pk_last[7] = 1'b1;
    run_packet(16'd8, 1'b0, 0, 1'b0, -1);
    check("t1_n_words", 64'(cap_data.size()), 64'(2));
    if (cap_data.size() == 2) begin
      check("t1_word0", 64'(cap_data[0]), 64'h0403_0201);
      check("t1_addr0", 64'(cap_addr[0]), 64'(0));
      check("t1_word1", 64'(cap_data[1]), 64'h0807_0605);
      check("t1_addr1", 64'(cap_addr[1]), 64'(1));
    end
    check("t1_count", 64'(in_count), 64'd8);

    // tlast-only length, zero-padded tail
    clear_pkt();
    for (int i = 0; i < 6; i++) pk_data[i] = DW'(8'hA0 + i);
    pk_last[5] = 1'b1;
    run_packet(16'd0, 1'b0, 0, 1'b0, -1);
    check("t2_n_words", 64'(cap_data.size()), 64'(2));
    if (cap_data.size() == 2) begin
      check("t2_word0", 64'(cap_data[0]), 64'hA3A2_A1A0);
      check("t2_word1", 64'(cap_data[1]), 64'h0000_A5A4);
    end
    check("t2_count", 64'(in_count), 64'd6);

    // tuser captured from first beat only
    clear_pkt();
    for (int i = 0; i < 3; i++) begin
      pk_data[i] = DW'(8'h30 + i);
      pk_user[i] = (i == 0) ? NW'(16) : NW'(3);
    end
    pk_last[2] = 1'b1;
    run_packet(16'd0, 1'b0, 30, 1'b0, -1);
    check("t3_nch", 64'(num_channels), 64'd16);

    // tvalid alternating, stray start during RECV
    clear_pkt();
    for (int i = 0; i < 4; i++) pk_data[i] = DW'(8'h11 * (i + 1));
    pk_last[3] = 1'b1;
    run_packet(16'd4, 1'b1, 0, 1'b1, -1);
    check("t4_n_words", 64'(cap_data.size()), 64'(1));
    if (cap_data.size() == 1) check("t4_word0", 64'(cap_data[0]), 64'h4433_2211);

    // reset after beat 5 of 8, then restart from address 0
    clear_pkt();
    for (int i = 0; i < 8; i++) pk_data[i] = DW'(8'hC0 + i);
    pk_last[7] = 1'b1;
    run_packet(16'd8, 1'b0, 0, 1'b0, 5);
    check("t5_n_words", 64'(cap_data.size()), 64'(1));
    run_packet(16'd8, 1'b0, 0, 1'b0, -1);
    check("t5_restart_words", 64'(cap_data.size()), 64'(2));
    if (cap_data.size() == 2) begin
      check("t5_restart_addr0", 64'(cap_addr[0]), 64'(0));
      check("t5_restart_word0", 64'(cap_data[0]), 64'hC3C2_C1C0);
    end

    // early tlast against size 8, then a clean packet
    clear_pkt();
    for (int i = 0; i < 5; i++) pk_data[i] = DW'(8'h50 + i);
    pk_last[4] = 1'b1;
    run_packet(16'd8, 1'b0, 0, 1'b0, -1);
    check("t6_n_words", 64'(cap_data.size()), 64'(2));
    if (cap_data.size() == 2) check("t6_word1", 64'(cap_data[1]), 64'h0000_0054);
    clear_pkt();
    pk_data[0] = 8'h77;
    pk_last[0] = 1'b1;
    run_packet(16'd1, 1'b0, 0, 1'b0, -1);

    // random packets
    for (int p = 0; p < 40; p++) begin
      int nb;
      logic [ZW-1:0] sz;
      clear_pkt();
      nb = $urandom_range(1, 20);
      for (int i = 0; i < nb; i++) begin
        pk_data[i] = DW'($urandom);
        pk_user[i] = NW'($urandom_range(0, 64));
        pk_last[i] = ($urandom_range(0, 9) == 0);
      end
      pk_last[nb-1] = 1'b1;
      sz = ($urandom_range(0, 2) == 0) ? '0 : ZW'($urandom_range(1, 22));
      run_packet(sz, 1'b0, $urandom_range(0, 50), bit'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
